// File: rtl/mem_reg_bridge_pkg.sv
// Shared constants for the byte-wide register front end of mem_reg_bridge:
// register offsets, status bit positions and the transaction FSM state type.
package mem_reg_bridge_pkg;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_ADDR0  = 4'h1;
  localparam logic [3:0] OFF_ADDR1  = 4'h2;
  localparam logic [3:0] OFF_ADDR2  = 4'h3;
  localparam logic [3:0] OFF_WDATA0 = 4'h4;
  localparam logic [3:0] OFF_WDATA1 = 4'h5;
  localparam logic [3:0] OFF_WDATA2 = 4'h6;
  localparam logic [3:0] OFF_WDATA3 = 4'h7;
  localparam logic [3:0] OFF_RD_CMD = 4'h8;
  localparam logic [3:0] OFF_WR_CMD = 4'h9;
  localparam logic [3:0] OFF_RDATA0 = 4'hA;
  localparam logic [3:0] OFF_RDATA1 = 4'hB;
  localparam logic [3:0] OFF_RDATA2 = 4'hC;
  localparam logic [3:0] OFF_RDATA3 = 4'hD;
  localparam logic [3:0] OFF_CTRL   = 4'hE;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;
  localparam int CTRL_AUTO_INC = 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic done,
                                             input logic error);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUSY]  = busy;
    s[STAT_DONE]  = done;
    s[STAT_ERROR] = error;
    return s;
  endfunction

endpackage

// File: rtl/mem_reg_bridge_regs.sv
// Register file of mem_reg_bridge: address/write-data/read-data/control
// registers, command edge detection and the registered readback mux.
module mem_reg_bridge_regs
  import mem_reg_bridge_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic [3:0]        offset,
  input  logic              write,
  input  logic              busy,
  input  logic              done,
  input  logic              error,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rdata_load,
  input  logic              addr_inc,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] addr_reg,
  output logic [DATA_W-1:0] wdata_reg,
  output logic              auto_inc,
  output logic              cmd_rd,
  output logic              cmd_wr,
  output logic              clr_done,
  output logic              clr_error
);

  logic [DATA_W-1:0] rdata_reg;
  logic              rd_hit, wr_hit, rd_hit_q, wr_hit_q;
  logic [7:0]        rd_mux;
  logic [23:0]       addr_pad;
  logic [31:0]       wdata_pad, rdata_pad;
  logic              reg_wr_ok;

  // Byte lanes beyond the configured width fall off through the truncating casts.
  function automatic logic [ADDR_W-1:0] put_addr(input logic [ADDR_W-1:0] cur,
                                                 input logic [1:0] idx,
                                                 input logic [7:0] b);
    logic [23:0] m, v;
    m = 24'h0000FF << {idx, 3'b000};
    v = {16'h0000, b} << {idx, 3'b000};
    return (cur & ~ADDR_W'(m)) | ADDR_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] put_data(input logic [DATA_W-1:0] cur,
                                                 input logic [1:0] idx,
                                                 input logic [7:0] b);
    logic [31:0] m, v;
    m = 32'h000000FF << {idx, 3'b000};
    v = {24'h000000, b} << {idx, 3'b000};
    return (cur & ~DATA_W'(m)) | DATA_W'(v);
  endfunction

  assign rd_hit    = write && (offset == OFF_RD_CMD);
  assign wr_hit    = write && (offset == OFF_WR_CMD);
  assign cmd_rd    = rd_hit && !rd_hit_q;
  assign cmd_wr    = wr_hit && !wr_hit_q;
  assign clr_done  = write && (offset == OFF_STATUS) && data_in[STAT_DONE];
  assign clr_error = write && (offset == OFF_STATUS) && data_in[STAT_ERROR];
  assign reg_wr_ok = write && !busy;

  assign addr_pad  = 24'(addr_reg);
  assign wdata_pad = 32'(wdata_reg);
  assign rdata_pad = 32'(rdata_reg);

  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      OFF_STATUS: rd_mux = status_byte(busy, done, error);
      OFF_ADDR0:  rd_mux = addr_pad[7:0];
      OFF_ADDR1:  rd_mux = addr_pad[15:8];
      OFF_ADDR2:  rd_mux = addr_pad[23:16];
      OFF_WDATA0: rd_mux = wdata_pad[7:0];
      OFF_WDATA1: rd_mux = wdata_pad[15:8];
      OFF_WDATA2: rd_mux = wdata_pad[23:16];
      OFF_WDATA3: rd_mux = wdata_pad[31:24];
      OFF_RDATA0: rd_mux = rdata_pad[7:0];
      OFF_RDATA1: rd_mux = rdata_pad[15:8];
      OFF_RDATA2: rd_mux = rdata_pad[23:16];
      OFF_RDATA3: rd_mux = rdata_pad[31:24];
      OFF_CTRL:   rd_mux = {7'b0000000, auto_inc};
      default:    rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      auto_inc  <= 1'b0;
      rd_hit_q  <= 1'b0;
      wr_hit_q  <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      rd_hit_q <= rd_hit;
      wr_hit_q <= wr_hit;
      data_out <= rd_mux;

      if (rdata_load)
        rdata_reg <= mem_rdata;

      // Completion only happens while busy, so it never collides with a CPU write.
      if (addr_inc)
        addr_reg <= addr_reg + ADDR_W'(1);
      else if (reg_wr_ok) begin
        case (offset)
          OFF_ADDR0: addr_reg <= put_addr(addr_reg, 2'd0, data_in);
          OFF_ADDR1: addr_reg <= put_addr(addr_reg, 2'd1, data_in);
          OFF_ADDR2: addr_reg <= put_addr(addr_reg, 2'd2, data_in);
          default: ;
        endcase
      end

      if (reg_wr_ok) begin
        case (offset)
          OFF_WDATA0: wdata_reg <= put_data(wdata_reg, 2'd0, data_in);
          OFF_WDATA1: wdata_reg <= put_data(wdata_reg, 2'd1, data_in);
          OFF_WDATA2: wdata_reg <= put_data(wdata_reg, 2'd2, data_in);
          OFF_WDATA3: wdata_reg <= put_data(wdata_reg, 2'd3, data_in);
          OFF_CTRL:   auto_inc  <= data_in[CTRL_AUTO_INC];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_reg_bridge.sv
// Byte-wide register port to a word-addressed memory request/ack interface.
// Define MEM_REG_BRIDGE_TIMEOUT_EN to abort requests after TIMEOUT_CYC cycles.
module mem_reg_bridge
  import mem_reg_bridge_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic [3:0]        addr_mem_interface,
  input  logic              write,
  input  logic              read,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy
);

  state_t      state, state_n;
  logic        start, finish;
  logic        we_q, done_q, error_q;
  logic        cmd_rd, cmd_wr, clr_done, clr_error, auto_inc;
  logic        rdata_load, addr_inc;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  // Readback is unconditional, so the read strobe carries no information.
  logic        unused_read;

  assign unused_read = read;

`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        timeout;
`endif

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cmd_rd || cmd_wr) begin
          start   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
        else if (to_cnt == 16'(TIMEOUT_CYC - 1)) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        we_q    <= cmd_wr;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        if (finish)
          done_q <= 1'b1;
        else if (clr_done)
          done_q <= 1'b0;
`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
        if (timeout)
          error_q <= 1'b1;
        else if (clr_error)
          error_q <= 1'b0;
`else
        if (clr_error)
          error_q <= 1'b0;
`endif
      end
    end
  end

`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      to_cnt <= 16'h0000;
    else if (state == REQ)
      to_cnt <= to_cnt + 16'h0001;
    else
      to_cnt <= 16'h0000;
  end
`endif

  // Address and write data come straight from the registers, which are frozen while busy.
  assign mem_req    = (state == REQ);
  assign busy       = (state == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign rdata_load = finish && !we_q;
  assign addr_inc   = finish && auto_inc;

  mem_reg_bridge_regs #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .offset     (addr_mem_interface),
    .write      (write),
    .busy       (busy),
    .done       (done_q),
    .error      (error_q),
    .mem_rdata  (mem_rdata),
    .rdata_load (rdata_load),
    .addr_inc   (addr_inc),
    .data_out   (data_out),
    .addr_reg   (addr_reg),
    .wdata_reg  (wdata_reg),
    .auto_inc   (auto_inc),
    .cmd_rd     (cmd_rd),
    .cmd_wr     (cmd_wr),
    .clr_done   (clr_done),
    .clr_error  (clr_error)
  );

endmodule

// File: tb/tb_mem_reg_bridge.sv
// Directed bench for mem_reg_bridge: register table plus transaction sequences.
module tb_mem_reg_bridge;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic              clk;
  logic              reset;
  logic [7:0]        data_in;
  logic [3:0]        addr_mem_interface;
  logic              write;
  logic              read;
  logic [7:0]        data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;
  logic              busy;

  mem_reg_bridge #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .data_in            (data_in),
    .addr_mem_interface (addr_mem_interface),
    .write              (write),
    .read               (read),
    .data_out           (data_out),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_ack            (mem_ack),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int req_count = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !req_prev) req_count = req_count + 1;
    req_prev = mem_req;
  end

  typedef struct {
    logic       do_wr;
    logic [3:0] off;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [7:0] d);
    @(negedge clk);
    addr_mem_interface = off;
    data_in = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [7:0] v);
    @(negedge clk);
    addr_mem_interface = off;
    read = 1'b1;
    @(negedge clk);
    v = data_out;
    read = 1'b0;
  endtask

  task automatic ack_pulse(input logic [DATA_W-1:0] d);
    @(negedge clk);
    mem_rdata = d;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  logic [7:0] rb;
  int rc0;
  int hi_cnt;

  initial begin
    reset = 1'b0;
    data_in = 8'h00;
    addr_mem_interface = 4'h0;
    write = 1'b0;
    read = 1'b0;
    mem_rdata = '0;
    mem_ack = 1'b0;

    vecs[0]  = '{1'b0, 4'h0, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 4'h1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 4'hE, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 4'hA, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 4'h1, 8'h5A, 8'h5A};
    vecs[5]  = '{1'b1, 4'h2, 8'h3C, 8'h3C};
    vecs[6]  = '{1'b1, 4'h3, 8'hFF, 8'h7F};
    vecs[7]  = '{1'b1, 4'h4, 8'h11, 8'h11};
    vecs[8]  = '{1'b1, 4'h5, 8'h22, 8'h22};
    vecs[9]  = '{1'b1, 4'h6, 8'h33, 8'h00};
    vecs[10] = '{1'b1, 4'h7, 8'h44, 8'h00};
    vecs[11] = '{1'b1, 4'hE, 8'hFF, 8'h01};
    vecs[12] = '{1'b1, 4'hE, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 4'hF, 8'h00, 8'h00};
    vecs[14] = '{1'b1, 4'h0, 8'hFF, 8'h00};

    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_wr) reg_wr(vecs[i].off, vecs[i].wdata);
      reg_rd(vecs[i].off, rb);
      check($sformatf("vec%0d_off%0h", i, vecs[i].off), 32'(rb), 32'(vecs[i].exp));
    end

    // Write command held for five cycles, ack arriving while still held
    reg_wr(4'h1, 8'h05);
    reg_wr(4'h2, 8'h00);
    reg_wr(4'h3, 8'h00);
    reg_wr(4'h4, 8'hA5);
    reg_wr(4'h5, 8'hC2);
    rc0 = req_count;
    @(negedge clk);
    addr_mem_interface = 4'h9;
    data_in = 8'h00;
    write = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("wr_mem_req", 32'(mem_req), 32'h1);
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_busy", 32'(busy), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h000005);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hC2A5);
      end
      mem_ack = (i == 2);
    end
    write = 1'b0;
    mem_ack = 1'b0;
    check("wr_req_low", 32'(mem_req), 32'h0);
    check("wr_single_req", 32'(req_count - rc0), 32'h1);
    reg_rd(4'h0, rb);
    check("wr_status_done", 32'(rb), 32'h02);

    // Read command
    reg_wr(4'h8, 8'h00);
    check("rd_mem_req", 32'(mem_req), 32'h1);
    check("rd_mem_we", 32'(mem_we), 32'h0);
    check("rd_mem_addr", 32'(mem_addr), 32'h000005);
    ack_pulse(16'hC2A5);
    check("rd_busy_low", 32'(busy), 32'h0);
    reg_rd(4'hA, rb);
    check("rd_byte0", 32'(rb), 32'hA5);
    reg_rd(4'hB, rb);
    check("rd_byte1", 32'(rb), 32'hC2);
    reg_rd(4'hC, rb);
    check("rd_byte2", 32'(rb), 32'h00);

    // Stray ack in IDLE must not touch status
    reg_wr(4'h0, 8'h02);
    ack_pulse(16'hFFFF);
    reg_rd(4'h0, rb);
    check("idle_ack_status", 32'(rb), 32'h00);
    reg_rd(4'hA, rb);
    check("idle_ack_rdata", 32'(rb), 32'hA5);

    // Auto-increment wrap
    reg_wr(4'hE, 8'h01);
    reg_wr(4'h1, 8'hFF);
    reg_wr(4'h2, 8'hFF);
    reg_wr(4'h3, 8'hFF);
    reg_wr(4'h9, 8'h00);
    check("wrap_mem_addr", 32'(mem_addr), 32'h7FFFFF);
    ack_pulse(16'h0000);
    check("wrap_mem_addr_after", 32'(mem_addr), 32'h000000);
    reg_rd(4'h1, rb);
    check("wrap_addr0", 32'(rb), 32'h00);
    reg_rd(4'h2, rb);
    check("wrap_addr1", 32'(rb), 32'h00);
    reg_rd(4'h3, rb);
    check("wrap_addr2", 32'(rb), 32'h00);

    // Commands and register writes dropped while busy
    reg_wr(4'hE, 8'h00);
    reg_wr(4'h1, 8'h20);
    rc0 = req_count;
    reg_wr(4'h8, 8'h00);
    reg_rd(4'h0, rb);
    check("busy_status", 32'(rb), 32'h01);
    reg_wr(4'h9, 8'h00);
    reg_wr(4'h1, 8'hFF);
    reg_wr(4'hE, 8'h01);
    repeat (2) @(negedge clk);
    check("busy_mem_we", 32'(mem_we), 32'h0);
    check("busy_mem_addr", 32'(mem_addr), 32'h000020);
    ack_pulse(16'h1234);
    repeat (3) @(negedge clk);
    check("busy_req_low", 32'(mem_req), 32'h0);
    check("busy_single_req", 32'(req_count - rc0), 32'h1);
    reg_rd(4'h1, rb);
    check("busy_addr_kept", 32'(rb), 32'h20);
    reg_rd(4'hE, rb);
    check("busy_ctrl_kept", 32'(rb), 32'h00);
    reg_rd(4'hB, rb);
    check("busy_rdata1", 32'(rb), 32'h12);

`ifdef MEM_REG_BRIDGE_TIMEOUT_EN
    // No ack: request aborts after TO_CYC cycles
    reg_wr(4'h9, 8'h00);
    hi_cnt = 0;
    while (mem_req && hi_cnt < 40) begin
      hi_cnt = hi_cnt + 1;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(hi_cnt), 32'(TO_CYC));
    reg_rd(4'h0, rb);
    check("to_status", 32'(rb), 32'h04);
    reg_wr(4'h0, 8'h04);
    reg_rd(4'h0, rb);
    check("to_status_clr", 32'(rb), 32'h00);
`else
    // No timeout logic: request stays up well beyond TIMEOUT_CYC
    reg_wr(4'h9, 8'h00);
    hi_cnt = 0;
    repeat (TO_CYC + 20) begin
      @(negedge clk);
      if (mem_req) hi_cnt = hi_cnt + 1;
    end
    check("noto_req_held", 32'(hi_cnt), 32'(TO_CYC + 20));
    reg_rd(4'h0, rb);
    check("noto_status", 32'(rb), 32'h01);
    ack_pulse(16'h0000);
    reg_rd(4'h0, rb);
    check("noto_status_done", 32'(rb), 32'h02);
`endif

    // Asynchronous reset during a read transaction
    reg_wr(4'h8, 8'h00);
    check("rst_pre_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("arst_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      reg_rd(4'(i), rb);
      check($sformatf("arst_rb_off%0h", i), 32'(rb), 32'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_reg_bridge.md
MEM_REG_BRIDGE -- requirements
Module: mem_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, memory word-address width (1..24).
REQ-002 SHALL have parameter DATA_W, default 16, memory data width (8, 16, 24 or 32).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, maximum cycles waiting for mem_ack (1..65535).
REQ-004 SHALL have the ports below, in this order:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  8  register write data.
- addr_mem_interface  in  4  register offset.
- write  in  1  register write strobe; level, may be held for several cycles.
- read  in  1  register read strobe.
- data_out  out  8  register read data.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1.
- mem_req  out  1  memory request.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_ack  in  1  one-cycle completion pulse from memory.
- busy  out  1  transaction in progress.

Function
REQ-005 Register map SHALL be:
- 0x0 status: bit0 busy, bit1 done, bit2 error, others 0.
- 0x1-0x3 address bytes LSB first.
- 0x4-0x7 write-data bytes LSB first.
- 0x8 read command.
- 0x9 write command.
- 0xA-0xD read-data bytes LSB first.
- 0xE control: bit0 auto-increment.
- 0xF reads 0x00.
REQ-006 Address and data byte bits beyond ADDR_W/DATA_W SHALL be discarded on write and read back as 0.
REQ-007 Register writes SHALL take effect every cycle write=1, except that writes to 0x1-0x7 and 0xE SHALL be ignored while busy=1.
REQ-008 A command SHALL fire only on the first cycle of write=1 with offset 0x8/0x9, i.e. the rising edge of (write & offset match); holding write SHALL NOT retrigger.
REQ-009 A command arriving while busy=1 SHALL be dropped without effect.
REQ-010 Writing 0x0 with data_in bit1 or bit2 set SHALL clear done or error respectively.
REQ-011 data_out SHALL be registered: on each cycle it takes the value addressed by addr_mem_interface, independent of read, giving 1-cycle latency.
REQ-012 FSM states SHALL be IDLE and REQ.
- IDLE->REQ on a valid command: mem_req=1; mem_we=1 for 0x9, 0 for 0x8; busy=1; done and error cleared.
REQ-013 In REQ, mem_addr, mem_we and mem_wdata SHALL hold stable until exit.
REQ-014 REQ->IDLE on mem_ack=1, with mem_req low the next cycle:
- done set.
- for a read, mem_rdata captured into the read-data register.
- if auto-increment=1, address register incremented by 1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-015 mem_ack received in IDLE SHALL be ignored.
REQ-016 Minimum command-to-next-command spacing SHALL be 2 cycles after ack; busy SHALL fall in the same cycle mem_req falls.

Reset
REQ-017 While reset=0, all registers SHALL clear asynchronously and outputs SHALL be 0: data_out, mem_addr, mem_wdata, mem_req, mem_we, busy, done, error and control.
REQ-018 Reset asserted mid-transaction SHALL abort it, drop mem_req immediately and leave the read-data register 0.

Configuration
REQ-019 With MEM_REG_BRIDGE_TIMEOUT_EN defined:
- a counter SHALL run in REQ.
- after TIMEOUT_CYC cycles without mem_ack, the FSM SHALL return to IDLE, set error, leave done clear, and skip the increment and read-data capture.
- mem_ack in the timeout cycle SHALL take priority over the timeout.
REQ-020 Without MEM_REG_BRIDGE_TIMEOUT_EN, REQ SHALL wait indefinitely, and error SHALL read 0.

Structure
REQ-021 Package mem_reg_bridge_pkg SHALL hold the register-offset constants, status bit indices and FSM state typedef.
REQ-022 Sub-module mem_reg_bridge_regs SHALL contain the register file and registered readback mux; the FSM and timeout SHALL stay in the top level.

Verification
REQ-023 The bench SHALL cover these scenarios (defaults unless stated):
- Write: write 0x1-0x3 = 0x05,0x00,0x00; 0x4/0x5 = 0xA5,0xC2; hold write on 0x9 for 5 cycles -> exactly one mem_req with mem_we=1, mem_addr=0x000005, mem_wdata=0xC2A5; done=1 after ack.
- Read: address 0x000005, command 0x8, memory returns 0xC2A5 -> 0xA,0xB read back 0xA5,0xC2 one cycle after offset applied.
- Auto-increment wrap: control=1, address 0x7FFFFF, write command -> mem_addr then address register reads 0x00,0x00,0x00.
- Busy drop: memory delays ack 10 cycles; issue a second command and write 0x1=0xFF during REQ -> single request; address register unchanged.
- Timeout: macro defined, TIMEOUT_CYC=8, no ack -> mem_req high exactly 8 cycles, status=0x04; write 0x0=0x04 -> status=0x00.
- Reset: reset low during REQ -> mem_req=0 and busy=0 without a clock edge; all readbacks 0x00.
